// File: rtl/vote_logger.sv
// Voting front end: synchronizes and debounces the buttons and keeps saturating tallies.
// Optional debounce filter is enabled with `define VOTE_LOGGER_DEBOUNCE_EN.
module vote_logger #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
    output logic       valid_vote_casted,
    output logic [7:0] candidate1_vote,
    output logic [7:0] candidate2_vote,
    output logic [7:0] candidate3_vote,
    output logic [7:0] candidate4_vote,
    output logic       vote_overflow
);

    typedef enum logic [1:0] {
        IDLE,
        CAST,
        LOCK
    } state_t;

    logic       mode_s1_q;
    logic       mode_s2_q;
    logic [3:0] btn_s1_q;
    logic [3:0] btn_s2_q;
    logic [3:0] deb;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_s1_q <= 1'b0;
            mode_s2_q <= 1'b0;
            btn_s1_q  <= '0;
            btn_s2_q  <= '0;
        end else begin
            mode_s1_q <= mode;
            mode_s2_q <= mode_s1_q;
            btn_s1_q  <= {button4, button3, button2, button1};
            btn_s2_q  <= btn_s1_q;
        end
    end

`ifdef VOTE_LOGGER_DEBOUNCE_EN
    localparam logic [23:0] DB_LIMIT = 24'(DEBOUNCE_CYCLES);

    logic [3:0][23:0] cnt_q;
    logic [3:0][23:0] cnt_d;
    logic [3:0]       deb_q;
    logic [3:0]       deb_d;

    // Any glitch back to the settled level restarts the stability count.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            if (btn_s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] + 24'd1 == DB_LIMIT) begin
                cnt_d[i] = '0;
                deb_d[i] = ~deb_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 24'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            deb_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign deb = deb_q;
`else
    logic unused_cfg;

    assign unused_cfg = ^32'(DEBOUNCE_CYCLES);
    assign deb        = btn_s2_q;
`endif

    state_t          state_q;
    state_t          state_d;
    logic [1:0]      sel_q;
    logic [1:0]      sel_d;
    logic [3:0][7:0] tally_q;
    logic [3:0][7:0] tally_d;
    logic            valid_q;
    logic            valid_d;
    logic            ovf_q;
    logic            ovf_d;
    logic            any_btn;
    logic            one_btn;

    assign any_btn = |deb;
    assign one_btn = any_btn && ((deb & (deb - 4'd1)) == 4'd0);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tally_d = tally_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (any_btn) begin
                    // Result mode or multi-press: wait for full release.
                    if (!mode_s2_q && one_btn) begin
                        state_d = CAST;
                        unique case (1'b1)
                            deb[0]:  sel_d = 2'd0;
                            deb[1]:  sel_d = 2'd1;
                            deb[2]:  sel_d = 2'd2;
                            deb[3]:  sel_d = 2'd3;
                            default: sel_d = sel_q;
                        endcase
                    end else begin
                        state_d = LOCK;
                    end
                end
            end
            CAST: begin
                if (tally_q[sel_q] != 8'hff) begin
                    tally_d[sel_q] = tally_q[sel_q] + 8'd1;
                    valid_d        = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
                state_d = LOCK;
            end
            LOCK: begin
                if (!any_btn) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            tally_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tally_q <= tally_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_vote_casted = valid_q;
    assign candidate1_vote   = tally_q[0];
    assign candidate2_vote   = tally_q[1];
    assign candidate3_vote   = tally_q[2];
    assign candidate4_vote   = tally_q[3];
    assign vote_overflow     = ovf_q;

endmodule

// File: tb/tb_vote_logger.sv
// Scoreboard bench for vote_logger: stimulus pushes expected pulses,
// a negedge monitor pops and checks tallies and pulse timing.
module tb_vote_logger;

    localparam int D = 4;
`ifdef VOTE_LOGGER_DEBOUNCE_EN
    localparam int LAT = 4 + D;
`else
    localparam int LAT = 4;
`endif
    localparam int HOLD = 20;
    localparam int REL  = 14;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       mode  = 1'b0;
    logic [3:0] btn   = '0;
    logic       valid_vote_casted;
    logic [7:0] c1, c2, c3, c4;
    logic       vote_overflow;

    vote_logger #(.DEBOUNCE_CYCLES(D)) dut (
        .clock            (clock),
        .reset            (reset),
        .mode             (mode),
        .button1          (btn[0]),
        .button2          (btn[1]),
        .button3          (btn[2]),
        .button4          (btn[3]),
        .valid_vote_casted(valid_vote_casted),
        .candidate1_vote  (c1),
        .candidate2_vote  (c2),
        .candidate3_vote  (c3),
        .candidate4_vote  (c4),
        .vote_overflow    (vote_overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] tallies;
        int          at;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] et[4];
    logic       exp_ovf = 1'b0;
    int         cyc = 0;
    int         vectors = 0;
    int         errors = 0;
    int         pulses = 0;
    logic       prev_valid = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] packed_exp();
        return {et[0], et[1], et[2], et[3]};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic check_outputs(string name);
        check({name, "_tallies"}, {c1, c2, c3, c4}, packed_exp());
        check({name, "_valid"}, 32'(valid_vote_casted), 32'd0);
        check({name, "_ovf"}, 32'(vote_overflow), 32'(exp_ovf));
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < 4; i++) et[i] = 8'd0;
        exp_ovf = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        clear_model();
        btn  = '0;
        mode = 1'b0;
        step(3);
        reset = 1'b1;
        step(2);
    endtask

    task automatic press(int idx, bit expect_vote);
        if (expect_vote) begin
            exp_t e;
            if (et[idx] != 8'hff) begin
                et[idx]   = et[idx] + 8'd1;
                e.tallies = packed_exp();
                e.at      = cyc + LAT;
                sb.push_back(e);
            end else begin
                exp_ovf = 1'b1;
            end
        end
        btn[idx] = 1'b1;
        step(HOLD);
        btn[idx] = 1'b0;
        step(REL);
    endtask

    always @(negedge clock) begin
        if (valid_vote_casted) begin
            exp_t e;
            pulses++;
            check("pulse_not_back_to_back", 32'(prev_valid), 32'd0);
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d, expected none",
                         cyc);
            end else begin
                e = sb.pop_front();
                check("tally_at_pulse", {c1, c2, c3, c4}, e.tallies);
                check("pulse_cycle", 32'(cyc), 32'(e.at));
            end
        end
        prev_valid = valid_vote_casted;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0;
        clear_model();
        step(2);
        check_outputs("in_reset");
        reset = 1'b1;
        step(2);
        check_outputs("after_reset");

        p0 = pulses;
        press(1, 1'b1);
        check("single_pending", 32'(sb.size()), 32'd0);
        check("single_pulses", 32'(pulses - p0), 32'd1);
        check_outputs("single");

`ifdef VOTE_LOGGER_DEBOUNCE_EN
        do_reset();
        p0 = pulses;
        repeat (10) begin
            btn[0] = ~btn[0];
            step(2);
        end
        btn[0] = 1'b0;
        step(REL);
        check("bounce_pulses", 32'(pulses - p0), 32'd0);
        check_outputs("bounce");
`endif

        p0 = pulses;
        btn = 4'b0101;
        step(HOLD);
        btn = 4'b0000;
        step(REL);
        check("simul_pulses", 32'(pulses - p0), 32'd0);
        check_outputs("simul");

        begin
            exp_t e;
            et[3]     = et[3] + 8'd1;
            e.tallies = packed_exp();
            e.at      = cyc + LAT;
            sb.push_back(e);
            p0 = pulses;
            btn[3] = 1'b1;
            step(10);
            btn[0] = 1'b1;
            step(HOLD);
            btn[0] = 1'b0;
            step(REL);
            btn[3] = 1'b0;
            step(REL);
            check("overlap_pulses", 32'(pulses - p0), 32'd1);
            check("overlap_pending", 32'(sb.size()), 32'd0);
            check_outputs("overlap");
        end

        do_reset();
        p0 = pulses;
        mode = 1'b1;
        step(4);
        btn[1] = 1'b1;
        step(HOLD);
        mode = 1'b0;
        step(HOLD);
        btn[1] = 1'b0;
        step(REL);
        check("mode_pulses", 32'(pulses - p0), 32'd0);
        check_outputs("mode_switch");
        press(1, 1'b1);
        check_outputs("mode_fresh");
        check("mode_fresh_c2", 32'(c2), 32'd1);

        do_reset();
        p0 = pulses;
        for (int i = 0; i < 256; i++) begin
            press(2, 1'b1);
            if (i == 254) begin
                check("sat_ovf_at_255", 32'(vote_overflow), 32'd0);
                check("sat_c3_at_255", 32'(c3), 32'd255);
            end
        end
        check("sat_pulses", 32'(pulses - p0), 32'd255);
        check("sat_pending", 32'(sb.size()), 32'd0);
        check("sat_c3", 32'(c3), 32'd255);
        check_outputs("saturate");

        do_reset();
        for (int i = 0; i < 5; i++) press(0, 1'b1);
        check("pre_c1", 32'(c1), 32'd5);
        btn[0] = 1'b1;
        step(LAT - 1);
        check_outputs("in_cast");
        #2;
        reset = 1'b0;
        clear_model();
        #1;
        check_outputs("async_reset");
        btn[0] = 1'b0;
        step(5);
        reset = 1'b1;
        step(3);
        press(0, 1'b1);
        check("post_reset_c1", 32'(c1), 32'd1);
        check("post_reset_pending", 32'(sb.size()), 32'd0);
        check_outputs("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
